// File: rtl/hopfield_seq_core_if.sv
// Command, result and weight-debug signals of hopfield_seq_core.
// The master side is the pattern source/controller and the slave side is the core.
interface hopfield_seq_core_if #(
  parameter int N       = 8,
  parameter int W_WIDTH = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [N-1:0]              cmd_pattern;
  logic                      done_valid;
  logic [N-1:0]              result_pattern;
  logic                      converged;
  logic [7:0]                sweep_count;
  logic [IW-1:0]             dbg_row;
  logic [IW-1:0]             dbg_col;
  logic signed [W_WIDTH-1:0] dbg_weight;

  modport master (
    output cmd_valid, cmd_op, cmd_pattern, dbg_row, dbg_col,
    input  cmd_ready, done_valid, result_pattern, converged, sweep_count, dbg_weight
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_pattern, dbg_row, dbg_col,
    output cmd_ready, done_valid, result_pattern, converged, sweep_count, dbg_weight
  );
endinterface

// File: rtl/hopfield_seq_core.sv
// Time-multiplexed binary Hopfield memory: Hebbian LEARN, CLEAR and sequential-update RECALL.
// Define HOPFIELD_UNLEARN_EN to turn op 11 into UNLEARN (anti-Hebbian); otherwise op 11 is a no-op.
module hopfield_seq_core #(
  parameter int N          = 8,
  parameter int W_WIDTH    = 8,
  parameter int MAX_SWEEPS = 16
) (
  input  logic                clk,
  input  logic                reset,
  hopfield_seq_core_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = W_WIDTH + $clog2(N) + 1;
  localparam logic signed [W_WIDTH-1:0] WMAX = {1'b0, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [W_WIDTH-1:0] WONE = W_WIDTH'(1);
  localparam logic [IW-1:0]             LAST = IW'(N - 1);
  localparam logic [7:0]                MAXS = 8'(MAX_SWEEPS);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LEARN, S_R_ACC, S_R_UPD, S_DONE} state_t;

  state_t                    state_q;
  logic signed [W_WIDTH-1:0] w_q [N][N];
  logic [N-1:0]              pat_q;
  logic [N-1:0]              x_q;
  logic [IW-1:0]             i_q;
  logic [IW-1:0]             j_q;
  logic signed [HW-1:0]      h_q;
  logic                      changed_q;
  logic [7:0]                sweeps_q;
  logic                      done_q;
  logic [N-1:0]              result_q;
  logic                      converged_q;
  logic [7:0]                sweep_count_q;
`ifdef HOPFIELD_UNLEARN_EN
  logic                      neg_q;
`endif

  logic signed [W_WIDTH-1:0] row_d [N];
  logic [N-1:0]              up_d;
  logic signed [HW-1:0]      wext_d;
  logic signed [HW-1:0]      h_d;
  logic                      xi_d;
  logic                      flip_d;
  logic [N-1:0]              x_d;
  logic [7:0]                sweeps_d;

  // Datapath for the current row: one Hebbian row update and one accumulate term per cycle.
  always_comb begin
    wext_d = HW'(w_q[i_q][j_q]);
    h_d    = h_q;
    if (j_q != i_q) h_d = x_q[j_q] ? (h_q + wext_d) : (h_q - wext_d);

    xi_d = h_q[HW-1] ? 1'b0 : ((h_q != '0) ? 1'b1 : x_q[i_q]);
    flip_d = (xi_d != x_q[i_q]);
    x_d = x_q;
    x_d[i_q] = xi_d;
    sweeps_d = sweeps_q + 8'd1;

    for (int j = 0; j < N; j++) begin
`ifdef HOPFIELD_UNLEARN_EN
      up_d[j] = (pat_q[i_q] == pat_q[j]) ^ neg_q;
`else
      up_d[j] = (pat_q[i_q] == pat_q[j]);
`endif
      row_d[j] = w_q[i_q][j];
      if (j != int'(i_q)) begin
        if (up_d[j] && (w_q[i_q][j] != WMAX))        row_d[j] = w_q[i_q][j] + WONE;
        else if (!up_d[j] && (w_q[i_q][j] != -WMAX)) row_d[j] = w_q[i_q][j] - WONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pat_q         <= '0;
      x_q           <= '0;
      i_q           <= '0;
      j_q           <= '0;
      h_q           <= '0;
      changed_q     <= 1'b0;
      sweeps_q      <= '0;
      done_q        <= 1'b0;
      result_q      <= '0;
      converged_q   <= 1'b0;
      sweep_count_q <= '0;
`ifdef HOPFIELD_UNLEARN_EN
      neg_q         <= 1'b0;
`endif
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          w_q[r][c] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            pat_q     <= bus.cmd_pattern;
            x_q       <= bus.cmd_pattern;
            i_q       <= '0;
            j_q       <= '0;
            h_q       <= '0;
            changed_q <= 1'b0;
            sweeps_q  <= '0;
            case (bus.cmd_op)
              2'b00: state_q <= S_CLEAR;
              2'b01: begin
                state_q <= S_LEARN;
`ifdef HOPFIELD_UNLEARN_EN
                neg_q   <= 1'b0;
`endif
              end
              2'b10: state_q <= S_R_ACC;
              default: begin
`ifdef HOPFIELD_UNLEARN_EN
                state_q <= S_LEARN;
                neg_q   <= 1'b1;
`else
                state_q <= S_DONE;
                done_q  <= 1'b1;
`endif
              end
            endcase
          end
        end
        S_CLEAR, S_LEARN: begin
          for (int j = 0; j < N; j++)
            w_q[i_q][j] <= (state_q == S_CLEAR) ? '0 : row_d[j];
          if (i_q == LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        S_R_ACC: begin
          h_q <= h_d;
          if (j_q == LAST) begin
            j_q     <= '0;
            state_q <= S_R_UPD;
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        S_R_UPD: begin
          x_q <= x_d;
          h_q <= '0;
          if (i_q != LAST) begin
            i_q       <= i_q + IW'(1);
            changed_q <= changed_q | flip_d;
            state_q   <= S_R_ACC;
          end else if (!(changed_q | flip_d) || (sweeps_d == MAXS)) begin
            // Sweep boundary: publish the recall outcome only when finishing.
            result_q      <= x_d;
            converged_q   <= !(changed_q | flip_d);
            sweep_count_q <= sweeps_d;
            sweeps_q      <= sweeps_d;
            state_q       <= S_DONE;
            done_q        <= 1'b1;
          end else begin
            i_q       <= '0;
            changed_q <= 1'b0;
            sweeps_q  <= sweeps_d;
            state_q   <= S_R_ACC;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = (state_q == S_IDLE);
  assign bus.done_valid     = done_q;
  assign bus.result_pattern = result_q;
  assign bus.converged      = converged_q;
  assign bus.sweep_count    = sweep_count_q;
  assign bus.dbg_weight     = w_q[bus.dbg_row][bus.dbg_col];
endmodule

// File: tb/tb_hopfield_seq_core.sv
// Self-checking bench for hopfield_seq_core against a behavioural Hopfield model.
// Honours HOPFIELD_UNLEARN_EN for the op 11 expectations.
module tb_hopfield_seq_core;
  localparam int N          = 8;
  localparam int W_WIDTH    = 8;
  localparam int MAX_SWEEPS = 16;
  localparam int WLIM       = 127;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int           wm [N][N];
  logic [N-1:0] mResult;
  bit           mConv;
  int           mSweeps;
  int           lat;

  hopfield_seq_core_if #(.N(N), .W_WIDTH(W_WIDTH)) bus ();

  hopfield_seq_core #(.N(N), .W_WIDTH(W_WIDTH), .MAX_SWEEPS(MAX_SWEEPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void mClear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        wm[i][j] = 0;
  endfunction

  // Hebbian rule with sign +1 (LEARN) or -1 (UNLEARN), clamped to +/-WLIM.
  function automatic void mLearn(input logic [N-1:0] p, input int sgn);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i != j) begin
          int v = wm[i][j] + sgn * ((p[i] == p[j]) ? 1 : -1);
          if (v > WLIM)  v = WLIM;
          if (v < -WLIM) v = -WLIM;
          wm[i][j] = v;
        end
  endfunction

  function automatic void mRecall(input logic [N-1:0] p);
    logic [N-1:0] x = p;
    bit changed;
    int h;
    mSweeps = 0;
    mConv   = 0;
    do begin
      changed = 0;
      for (int i = 0; i < N; i++) begin
        h = 0;
        for (int j = 0; j < N; j++)
          if (j != i) h += wm[i][j] * (x[j] ? 1 : -1);
        if (h > 0 && !x[i])     begin x[i] = 1'b1; changed = 1; end
        else if (h < 0 && x[i]) begin x[i] = 1'b0; changed = 1; end
      end
      mSweeps++;
      if (!changed) mConv = 1;
    end while (changed && mSweeps < MAX_SWEEPS);
    mResult = x;
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [N-1:0] pat);
    @(negedge clk);
    checkOutput("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_pattern = pat;
    @(posedge clk);
    #1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_pattern = N'($urandom);
    bus.cmd_op      = 2'($urandom);
  endtask

  // Cycles are counted from the acceptance edge to the cycle where done_valid is high.
  task automatic waitDone(input bit noise, output int cycles);
    int readyBusy = 0;
    bit seen = 0;
    cycles = 0;
    if (noise) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
    end
    while (!seen && cycles < 1300) begin
      @(negedge clk);
      cycles++;
      if (bus.done_valid === 1'b1) seen = 1;
      else if (bus.cmd_ready !== 1'b0) readyBusy++;
    end
    bus.cmd_valid = 1'b0;
    checkOutput("done_seen", seen, 1);
    checkOutput("ready_low_busy", readyBusy, 0);
    @(negedge clk);
    checkOutput("done_one_cycle", bus.done_valid, 0);
    checkOutput("ready_after_done", bus.cmd_ready, 1);
  endtask

  task automatic runCmd(input logic [1:0] op, input logic [N-1:0] pat, input bit noise,
                        output int cycles);
    applyStimulus(op, pat);
    waitDone(noise, cycles);
  endtask

  task automatic checkWeight(input int r, input int c, input string tag);
    bus.dbg_row = 3'(r);
    bus.dbg_col = 3'(c);
    #1;
    checkOutput(tag, bus.dbg_weight, wm[r][c]);
  endtask

  task automatic checkAllWeights(input string tag);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        checkWeight(r, c, tag);
  endtask

  task automatic checkRecall(input logic [N-1:0] probe, input string tag);
    int cyc;
    runCmd(2'b10, probe, 1'b0, cyc);
    mRecall(probe);
    checkOutput({tag, "_result"}, bus.result_pattern, mResult);
    checkOutput({tag, "_converged"}, bus.converged, mConv);
    checkOutput({tag, "_sweeps"}, bus.sweep_count, mSweeps);
    checkOutput({tag, "_latency"}, cyc, mSweeps * N * (N + 1) + 1);
  endtask

  initial begin
    int doneCount;
    logic [N-1:0] p;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 2'b00;
    bus.cmd_pattern = '0;
    bus.dbg_row     = '0;
    bus.dbg_col     = '0;
    mClear();
    mResult = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", bus.cmd_ready, 1);
    checkOutput("rst_done", bus.done_valid, 0);
    checkOutput("rst_result", bus.result_pattern, 0);
    checkOutput("rst_converged", bus.converged, 0);
    checkOutput("rst_sweeps", bus.sweep_count, 0);
    checkAllWeights("rst_weight");

    // Zero weights: every neuron sees h==0 and keeps its state.
    runCmd(2'b10, 8'hA5, 1'b0, lat);
    checkOutput("recall0_latency", lat, 73);
    checkOutput("recall0_result", bus.result_pattern, 8'hA5);
    checkOutput("recall0_converged", bus.converged, 1);
    checkOutput("recall0_sweeps", bus.sweep_count, 1);

    runCmd(2'b01, 8'hF0, 1'b0, lat);
    mLearn(8'hF0, 1);
    checkOutput("learn_latency", lat, 9);
    checkOutput("learn_keeps_result", bus.result_pattern, 8'hA5);
    checkOutput("learn_keeps_sweeps", bus.sweep_count, 1);
    checkWeight(0, 1, "w01_model");
    checkOutput("w01_const", bus.dbg_weight, 1);
    checkWeight(0, 4, "w04_model");
    checkOutput("w04_const", bus.dbg_weight, -1);
    checkWeight(3, 3, "w33_diag");
    checkWeight(5, 2, "w52");
    checkWeight(2, 5, "w25");
    checkOutput("w25_const", bus.dbg_weight, -1);

    checkRecall(8'hF1, "recallF1");
    checkOutput("recallF1_const", bus.result_pattern, 8'hF0);
    checkOutput("recallF1_sweeps_const", bus.sweep_count, 2);
    checkRecall(8'h0F, "recall0F");
    checkOutput("recall0F_const", bus.result_pattern, 8'h0F);

`ifdef HOPFIELD_UNLEARN_EN
    runCmd(2'b11, 8'hF0, 1'b0, lat);
    mLearn(8'hF0, -1);
    checkOutput("unlearn_latency", lat, 9);
    checkWeight(0, 1, "unlearn_w01");
    checkOutput("unlearn_w01_const", bus.dbg_weight, 0);
    checkAllWeights("unlearn_weight");
`else
    runCmd(2'b11, 8'hF0, 1'b0, lat);
    checkOutput("nop_latency", lat, 1);
    checkOutput("nop_keeps_result", bus.result_pattern, 8'h0F);
    checkAllWeights("nop_weight");
`endif

    // Randomized store/recall rounds.
    for (int it = 0; it < 3; it++) begin
      runCmd(2'b00, N'($urandom), 1'b0, lat);
      mClear();
      checkOutput("rnd_clear_latency", lat, 9);
      for (int k = 0; k < 2; k++) begin
        p = N'($urandom);
        runCmd(2'b01, p, 1'b0, lat);
        mLearn(p, 1);
      end
      for (int k = 0; k < 4; k++)
        checkWeight(int'($urandom_range(N - 1)), int'($urandom_range(N - 1)), "rnd_weight");
      for (int k = 0; k < 2; k++)
        checkRecall(N'($urandom), "rnd_recall");
    end

    // Saturation: repeated learning clamps at +/-127.
    runCmd(2'b00, '0, 1'b0, lat);
    mClear();
    for (int k = 0; k < 130; k++) begin
      runCmd(2'b01, 8'hF0, 1'b0, lat);
      mLearn(8'hF0, 1);
    end
    checkWeight(0, 1, "sat_w01");
    checkOutput("sat_w01_const", bus.dbg_weight, 127);
    checkWeight(0, 4, "sat_w04");
    checkOutput("sat_w04_const", bus.dbg_weight, -127);
    checkAllWeights("sat_weight");

    runCmd(2'b00, 8'hFF, 1'b0, lat);
    mClear();
    checkOutput("clear_latency", lat, 9);
    checkAllWeights("clear_weight");

    // A command held valid while busy must be dropped.
    runCmd(2'b01, 8'h3C, 1'b1, lat);
    mLearn(8'h3C, 1);
    checkOutput("busy_latency", lat, 9);
    doneCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done_valid === 1'b1) doneCount++;
    end
    checkOutput("busy_no_extra_done", doneCount, 0);
    checkAllWeights("busy_weight");

    // Reset in the middle of a recall.
    applyStimulus(2'b10, 8'h5A);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    mClear();
    checkOutput("midrst_ready", bus.cmd_ready, 1);
    checkOutput("midrst_done", bus.done_valid, 0);
    checkOutput("midrst_result", bus.result_pattern, 0);
    checkOutput("midrst_converged", bus.converged, 0);
    checkOutput("midrst_sweeps", bus.sweep_count, 0);
    checkAllWeights("midrst_weight");
    @(negedge clk);
    reset = 1'b0;
    doneCount = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done_valid === 1'b1) doneCount++;
    end
    checkOutput("midrst_no_done", doneCount, 0);
    checkOutput("midrst_ready_idle", bus.cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
